// File: rtl/lsu_mem_stage.sv
// Load/store stage: forwards ALU results to writeback in one cycle and turns
// loads/stores into a registered valid/ready request followed by a response.
module lsu_mem_stage (
   input  logic        clk,
   input  logic        rstn,
   input  logic        exu_valid,
   input  logic [63:0] exu_alu_result,
   input  logic [63:0] exu_gpr_data2,
   input  logic        exu_load_en,
   input  logic [2:0]  exu_load_opcode,
   input  logic        exu_store_en,
   input  logic [3:0]  exu_store_len,
   input  logic [4:0]  exu_index_rd,
   input  logic        exu_wb_en,
   output logic        lsu_stall,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [63:0] req_addr,
   output logic        req_wen,
   output logic [63:0] req_wdata,
   output logic [7:0]  req_wstrb,
   input  logic        rsp_valid,
   input  logic [63:0] rsp_rdata,
   output logic        wb_valid,
   output logic [4:0]  wb_index_rd,
   output logic        wb_en,
   output logic [63:0] wb_data,
   output logic        lsu_misalign
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t      state_q, state_d;
   logic [2:0]  off_q, off_d;
   logic        is_load_q, is_load_d;
   logic [2:0]  opcode_q, opcode_d;
   logic [4:0]  rd_q, rd_d;
   logic        cap_wb_en_q, cap_wb_en_d;

   logic        req_valid_q, req_valid_d;
   logic [63:0] req_addr_q, req_addr_d;
   logic        req_wen_q, req_wen_d;
   logic [63:0] req_wdata_q, req_wdata_d;
   logic [7:0]  req_wstrb_q, req_wstrb_d;
   logic        wb_valid_q, wb_valid_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic        wb_en_q, wb_en_d;
   logic [63:0] wb_data_q, wb_data_d;
   logic        misalign_q, misalign_d;

   logic        mem_op;
   logic [3:0]  size;
   logic [3:0]  size_mask;
   logic        misaligned;

   // Access size in bytes; undefined load opcodes and store lengths fall back to 8.
   function automatic logic [3:0] access_size(input logic       is_load,
                                              input logic [2:0] opcode,
                                              input logic [3:0] len);
      logic [3:0] s;
      if (is_load) begin
         case (opcode[1:0])
            2'b00:   s = 4'd1;
            2'b01:   s = 4'd2;
            2'b10:   s = 4'd4;
            default: s = 4'd8;
         endcase
      end else begin
         case (len)
            4'd1, 4'd2, 4'd4: s = len;
            default:          s = 4'd8;
         endcase
      end
      return s;
   endfunction

   function automatic logic [7:0] lane_strobe(input logic [3:0] sz, input logic [2:0] off);
      logic [15:0] m;
      m = ((16'd1 << sz) - 16'd1) << off;
      return m[7:0];
   endfunction

   function automatic logic [63:0] load_extract(input logic [63:0] rdata,
                                                input logic [2:0]  off,
                                                input logic [2:0]  opcode);
      logic [63:0] s;
      logic [63:0] r;
      s = rdata >> {off, 3'b000};
      case (opcode)
         3'b000:  r = {{56{s[7]}},  s[7:0]};
         3'b001:  r = {{48{s[15]}}, s[15:0]};
         3'b010:  r = {{32{s[31]}}, s[31:0]};
         3'b100:  r = {56'd0, s[7:0]};
         3'b101:  r = {48'd0, s[15:0]};
         3'b110:  r = {32'd0, s[31:0]};
         default: r = s;
      endcase
      return r;
   endfunction

   assign mem_op     = exu_load_en | exu_store_en;
   assign size       = access_size(exu_load_en, exu_load_opcode, exu_store_len);
   assign size_mask  = size - 4'd1;
   assign misaligned = |(exu_alu_result[2:0] & size_mask[2:0]);

   always_comb begin
      state_d     = state_q;
      off_d       = off_q;
      is_load_d   = is_load_q;
      opcode_d    = opcode_q;
      rd_d        = rd_q;
      cap_wb_en_d = cap_wb_en_q;
      req_valid_d = req_valid_q;
      req_addr_d  = req_addr_q;
      req_wen_d   = req_wen_q;
      req_wdata_d = req_wdata_q;
      req_wstrb_d = req_wstrb_q;
      wb_valid_d  = 1'b0;
      misalign_d  = 1'b0;
      wb_rd_d     = wb_rd_q;
      wb_en_d     = wb_en_q;
      wb_data_d   = wb_data_q;
      case (state_q)
         IDLE: begin
            if (exu_valid && !mem_op) begin
               wb_valid_d = 1'b1;
               wb_data_d  = exu_alu_result;
               wb_en_d    = exu_wb_en;
               wb_rd_d    = exu_index_rd;
            end else if (exu_valid) begin
               off_d       = exu_alu_result[2:0];
               is_load_d   = exu_load_en;
               opcode_d    = exu_load_opcode;
               rd_d        = exu_index_rd;
               cap_wb_en_d = exu_wb_en;
               if (misaligned) begin
                  // Faulting access completes immediately without touching the bus.
                  wb_valid_d = 1'b1;
                  misalign_d = 1'b1;
                  wb_en_d    = 1'b0;
                  wb_data_d  = 64'd0;
                  wb_rd_d    = exu_index_rd;
               end else begin
                  state_d     = REQ;
                  req_valid_d = 1'b1;
                  req_addr_d  = {exu_alu_result[63:3], 3'b000};
                  req_wen_d   = !exu_load_en;
                  req_wdata_d = exu_load_en ? 64'd0 : (exu_gpr_data2 << {exu_alu_result[2:0], 3'b000});
                  req_wstrb_d = exu_load_en ? 8'd0 : lane_strobe(size, exu_alu_result[2:0]);
               end
            end
         end
         REQ: begin
            if (req_ready) begin
               state_d     = WAIT;
               req_valid_d = 1'b0;
            end
         end
         WAIT: begin
            if (rsp_valid) begin
               state_d    = IDLE;
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               wb_en_d    = is_load_q ? cap_wb_en_q : 1'b0;
               wb_data_d  = is_load_q ? load_extract(rsp_rdata, off_q, opcode_q) : 64'd0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         off_q       <= 3'd0;
         is_load_q   <= 1'b0;
         opcode_q    <= 3'd0;
         rd_q        <= 5'd0;
         cap_wb_en_q <= 1'b0;
         req_valid_q <= 1'b0;
         req_addr_q  <= 64'd0;
         req_wen_q   <= 1'b0;
         req_wdata_q <= 64'd0;
         req_wstrb_q <= 8'd0;
         wb_valid_q  <= 1'b0;
         misalign_q  <= 1'b0;
         wb_rd_q     <= 5'd0;
         wb_en_q     <= 1'b0;
         wb_data_q   <= 64'd0;
      end else begin
         state_q     <= state_d;
         off_q       <= off_d;
         is_load_q   <= is_load_d;
         opcode_q    <= opcode_d;
         rd_q        <= rd_d;
         cap_wb_en_q <= cap_wb_en_d;
         req_valid_q <= req_valid_d;
         req_addr_q  <= req_addr_d;
         req_wen_q   <= req_wen_d;
         req_wdata_q <= req_wdata_d;
         req_wstrb_q <= req_wstrb_d;
         wb_valid_q  <= wb_valid_d;
         misalign_q  <= misalign_d;
         wb_rd_q     <= wb_rd_d;
         wb_en_q     <= wb_en_d;
         wb_data_q   <= wb_data_d;
      end
   end

   assign lsu_stall    = (state_q != IDLE);
   assign req_valid    = req_valid_q;
   assign req_addr     = req_addr_q;
   assign req_wen      = req_wen_q;
   assign req_wdata    = req_wdata_q;
   assign req_wstrb    = req_wstrb_q;
   assign wb_valid     = wb_valid_q;
   assign wb_index_rd  = wb_rd_q;
   assign wb_en        = wb_en_q;
   assign wb_data      = wb_data_q;
   assign lsu_misalign = misalign_q;

endmodule
